// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM state type, bubble instruction and latency legality check for imem_ctrl
package imem_pkg;
  typedef enum logic [1:0] {ST_RESET, ST_LOAD, ST_RUN} state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  function automatic bit lat_ok(input int lat);
    return lat inside {1, 2};
  endfunction
endpackage

// File: rtl/imem_if.sv
// imem_if: loader write port, fetch request and fetch response bundle for imem_ctrl
// master = loader/fetch unit side, slave = controller side; par_err exists only with IMEM_PARITY_EN
interface imem_if #(
  parameter int XLEN = 32,
  parameter int AW = 10
);
  logic ld_valid;
  logic [AW-1:0] ld_addr;
  logic [XLEN-1:0] ld_data;
  logic ld_done;
  logic ld_ready;
  logic fe_req;
  logic [XLEN-1:0] fe_pc;
  logic fe_stall;
  logic [XLEN-1:0] instr;
  logic instr_valid;
  logic [XLEN-1:0] instr_pc;
  logic fault;
  logic running;
`ifdef IMEM_PARITY_EN
  logic par_err;
`endif
  modport master (
    output ld_valid, ld_addr, ld_data, ld_done, fe_req, fe_pc, fe_stall,
    input ld_ready, instr, instr_valid, instr_pc, fault, running
`ifdef IMEM_PARITY_EN
    , par_err
`endif
  );
  modport slave (
    input ld_valid, ld_addr, ld_data, ld_done, fe_req, fe_pc, fe_stall,
    output ld_ready, instr, instr_valid, instr_pc, fault, running
`ifdef IMEM_PARITY_EN
    , par_err
`endif
  );
endinterface

// File: rtl/imem_ram.sv
// imem_ram: single-port synchronous RAM, DEPTH x W, write-enable and registered read data
// Ports: clk, we_i (write), re_i (read), addr_i, wdata_i, rdata_o (holds when neither strobe is set)
module imem_ram #(
  parameter int W = 32,
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: IF-stage instruction memory controller with LOAD/RUN FSM, fetch pipeline and fault decode
// Ports: clk, rst_n (async active-low), bus (imem_if.slave: loader port, fetch request, fetch response)
// Build option: IMEM_PARITY_EN stores an even-parity bit per word and drives bus.par_err
module imem_ctrl #(
  parameter int XLEN = 32,
  parameter int DEPTH = 1024,
  parameter int READ_LAT = 1,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
  input logic   clk,
  input logic   rst_n,
  imem_if.slave bus
);
  import imem_pkg::*;
  localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int W = XLEN + 1;
`else
  localparam int W = XLEN;
`endif
  if (!lat_ok(READ_LAT)) begin : g_bad_lat
    $error("imem_ctrl: READ_LAT must be 1 or 2");
  end
  state_e state_q, state_d;
  logic [XLEN-1:0] off, pc1_q;
  logic [AW-1:0] addr;
  logic [W-1:0] wdata, rdata, s1_word, out_word;
  logic bad, acc, we, v1_q, f1_q, hit1;
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RESET) state_d = ST_LOAD;
    else if (state_q == ST_LOAD && bus.ld_done) state_d = ST_RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_RESET;
    else state_q <= state_d;
  assign bus.ld_ready = state_q == ST_LOAD;
  assign bus.running = state_q == ST_RUN;
  // unsigned offset: a PC below BASE_ADDR wraps to a huge value and lands in the range fault
  assign off = bus.fe_pc - BASE_ADDR;
  assign bad = (off[1:0] != 2'b00) || ((off >> (AW + 2)) != '0);
  assign acc = state_q == ST_RUN && bus.fe_req && !bus.fe_stall;
  assign we = state_q == ST_LOAD && bus.ld_valid;
  assign addr = we ? bus.ld_addr : off[AW+1:2];
  imem_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .we_i(we), .re_i(acc && !bad), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q <= 1'b0;
      f1_q <= 1'b0;
      pc1_q <= '0;
    end else if (!bus.fe_stall) begin
      v1_q <= acc;
      f1_q <= acc && bad;
      pc1_q <= bus.fe_pc;
    end
  // RAM read data only advances on a non-faulting accept, so it is stable through stalls
  assign hit1 = v1_q && !f1_q;
`ifdef IMEM_PARITY_EN
  assign wdata = {^bus.ld_data, bus.ld_data};
  assign s1_word = hit1 ? {^rdata, rdata[XLEN-1:0]} : {1'b0, NOP_INSTR};
  assign bus.par_err = out_word[XLEN];
`else
  assign wdata = bus.ld_data;
  assign s1_word = hit1 ? rdata : NOP_INSTR;
`endif
  assign bus.instr = out_word[XLEN-1:0];
  if (READ_LAT == 2) begin : g_lat2
    logic v2_q, f2_q;
    logic [XLEN-1:0] pc2_q;
    logic [W-1:0] w2_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v2_q <= 1'b0;
        f2_q <= 1'b0;
        pc2_q <= '0;
        w2_q <= W'(NOP_INSTR);
      end else if (!bus.fe_stall) begin
        v2_q <= v1_q;
        f2_q <= f1_q;
        pc2_q <= pc1_q;
        w2_q <= s1_word;
      end
    assign bus.instr_valid = v2_q;
    assign bus.fault = f2_q;
    assign bus.instr_pc = pc2_q;
    assign out_word = w2_q;
  end else begin : g_lat1
    assign bus.instr_valid = v1_q;
    assign bus.fault = f1_q;
    assign bus.instr_pc = pc1_q;
    assign out_word = s1_word;
  end
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: self-checking bench driving a READ_LAT=1/BASE=0 and a READ_LAT=2/BASE=0x1000 controller in lockstep
module tb_imem_ctrl;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  typedef struct packed {
    logic v;
    logic f;
    logic pe;
    logic [31:0] instr;
    logic [31:0] pc;
  } resp_t;
  localparam resp_t BUB = '{v: 1'b0, f: 1'b0, pe: 1'b0, instr: NOP, pc: 32'h0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ld_valid = 1'b0, ld_done = 1'b0, fe_req = 1'b0, fe_stall = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0] ld_data = '0, fe_off = '0;
  logic [31:0] mem_m [DEPTH];
  bit perr_m [DEPTH];
  logic [31:0] spec_w [4] = '{32'h00100093, 32'h00000113, 32'h002081b3, 32'h0000006f};
  resp_t hist[$];
  int st_m = 0;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  imem_if #(.XLEN(32), .AW(AW)) b0 ();
  imem_if #(.XLEN(32), .AW(AW)) b1 ();
  assign b0.ld_valid = ld_valid;
  assign b0.ld_addr = ld_addr;
  assign b0.ld_data = ld_data;
  assign b0.ld_done = ld_done;
  assign b0.fe_req = fe_req;
  assign b0.fe_pc = fe_off + BASE0;
  assign b0.fe_stall = fe_stall;
  assign b1.ld_valid = ld_valid;
  assign b1.ld_addr = ld_addr;
  assign b1.ld_data = ld_data;
  assign b1.ld_done = ld_done;
  assign b1.fe_req = fe_req;
  assign b1.fe_pc = fe_off + BASE1;
  assign b1.fe_stall = fe_stall;
  imem_ctrl #(.XLEN(32), .DEPTH(DEPTH), .READ_LAT(1), .BASE_ADDR(BASE0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  imem_ctrl #(.XLEN(32), .DEPTH(DEPTH), .READ_LAT(2), .BASE_ADDR(BASE1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  function automatic resp_t got(int d);
    resp_t r;
    r.v = (d != 0) ? b1.instr_valid : b0.instr_valid;
    r.f = (d != 0) ? b1.fault : b0.fault;
    r.instr = (d != 0) ? b1.instr : b0.instr;
    r.pc = r.v ? ((d != 0) ? b1.instr_pc : b0.instr_pc) : 32'h0;
`ifdef IMEM_PARITY_EN
    r.pe = (d != 0) ? b1.par_err : b0.par_err;
`else
    r.pe = 1'b0;
`endif
    return r;
  endfunction

  // response the spec demands for the current request, pc held as an offset from the base
  function automatic resp_t model_resp();
    resp_t r = BUB;
    if (st_m != 2 || !fe_req) return BUB;
    r.v = 1'b1;
    r.pc = fe_off;
    if (fe_off[1:0] != 2'b00 || fe_off >= 32'(DEPTH * 4)) r.f = 1'b1;
    else begin
      r.instr = mem_m[fe_off[5:2]];
      r.pe = perr_m[fe_off[5:2]];
    end
    return r;
  endfunction

  // a DUT with latency L shows the response to the L-th most recent non-stalled cycle
  function automatic resp_t expect_r(int d);
    resp_t r;
    int n = hist.size() - (d + 1);
    if (n < 0) return BUB;
    r = hist[n];
    if (r.v) r.pc = r.pc + ((d != 0) ? BASE1 : BASE0);
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      if (!fe_stall) begin
        hist.push_back(model_resp());
        if (hist.size() > 4) void'(hist.pop_front());
      end
      if (st_m == 0) st_m = 1;
      else if (st_m == 1) begin
        if (ld_valid) begin
          mem_m[ld_addr] = ld_data;
          perr_m[ld_addr] = 1'b0;
        end
        if (ld_done) st_m = 2;
      end
    end
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    st_m = 0;
    hist.delete();
  endtask

  task automatic test_reset();
    assert_reset();
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got(d) !== BUB || expect_r(d) !== BUB) begin
        fails++;
        $display("FAIL reset_out dut%0d got=%h exp=%h", d, got(d), BUB);
      end
    end
    checks++;
    if ({b0.instr_pc, b1.instr_pc} !== 64'h0) begin
      fails++;
      $display("FAIL reset_pc got=%h/%h exp=0", b0.instr_pc, b1.instr_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({b0.ld_ready, b0.running, b1.ld_ready, b1.running} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_status got=%b exp=0000", {b0.ld_ready, b0.running, b1.ld_ready, b1.running});
    end
    cycle();
    checks++;
    if ({b0.ld_ready, b0.running, b1.ld_ready, b1.running} !== 4'b1010) begin
      fails++;
      $display("FAIL enter_load got=%b exp=1010", {b0.ld_ready, b0.running, b1.ld_ready, b1.running});
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1;
      ld_addr = AW'(i);
      ld_data = (i < 4) ? spec_w[i] : $urandom();
      ld_done = (i == DEPTH - 1);
      fe_req = $urandom_range(0, 1) == 1;
      fe_off = 32'($urandom_range(0, 15)) << 2;
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got(d) !== expect_r(d)) begin
          fails++;
          $display("FAIL load_nofetch dut%0d got=%h exp=%h", d, got(d), expect_r(d));
        end
      end
    end
    checks++;
    if ({b0.ld_ready, b0.running, b1.ld_ready, b1.running} !== 4'b0101) begin
      fails++;
      $display("FAIL enter_run got=%b exp=0101", {b0.ld_ready, b0.running, b1.ld_ready, b1.running});
    end
    ld_done = 1'b0;
    ld_addr = '0;
    ld_data = 32'hdead_beef;
    fe_req = 1'b0;
    cycle();
    ld_valid = 1'b0;
    checks++;
    if ({b0.ld_ready, b0.running, b1.ld_ready, b1.running} !== {2{1'(st_m == 1), 1'(st_m == 2)}}) begin
      fails++;
      $display("FAIL run_status got=%b st=%0d", {b0.ld_ready, b0.running, b1.ld_ready, b1.running}, st_m);
    end
  endtask

  task automatic test_seq_fetch();
    for (int i = 0; i < 6; i++) begin
      fe_req = i < 4;
      fe_off = 32'(i * 4);
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got(d) !== expect_r(d)) begin
          fails++;
          $display("FAIL seq dut%0d step%0d got=%h exp=%h", d, i, got(d), expect_r(d));
        end
      end
      if (i < 4) begin
        checks++;
        if (b0.instr !== spec_w[i] || b0.instr_pc !== 32'(i * 4) || b0.instr_valid !== 1'b1) begin
          fails++;
          $display("FAIL seq_lat1 step%0d got=%h pc=%h exp=%h", i, b0.instr, b0.instr_pc, spec_w[i]);
        end
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (b1.instr !== spec_w[i-1] || b1.instr_pc !== BASE1 + 32'((i - 1) * 4)) begin
          fails++;
          $display("FAIL seq_lat2 step%0d got=%h pc=%h exp=%h", i, b1.instr, b1.instr_pc, spec_w[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 9; i++) begin
      fe_stall = i >= 2 && i < 5;
      fe_req = i < 7;
      fe_off = (i < 2) ? 32'(i * 4) : (i < 5) ? 32'd8 : 32'((i - 3) * 4);
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got(d) !== expect_r(d)) begin
          fails++;
          $display("FAIL stall dut%0d step%0d got=%h exp=%h", d, i, got(d), expect_r(d));
        end
      end
      if (i >= 1 && i < 5) begin
        checks++;
        if (b0.instr !== 32'h00000113 || b0.instr_pc !== 32'h4) begin
          fails++;
          $display("FAIL stall_hold step%0d got=%h pc=%h exp=00000113", i, b0.instr, b0.instr_pc);
        end
      end
    end
    fe_stall = 1'b0;
  endtask

  task automatic test_faults();
    logic [31:0] offs [5] = '{32'h2, 32'(DEPTH * 4), 32'hFFFF_FFFC, 32'(DEPTH * 4 - 4), 32'h1};
    for (int i = 0; i < 7; i++) begin
      fe_req = i < 5;
      fe_off = (i < 5) ? offs[i] : 32'h0;
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got(d) !== expect_r(d)) begin
          fails++;
          $display("FAIL fault dut%0d step%0d got=%h exp=%h", d, i, got(d), expect_r(d));
        end
      end
      if (i < 5) begin
        checks++;
        if (b0.fault !== (i != 3) || b0.instr_valid !== 1'b1 || (i != 3 && b0.instr !== NOP)) begin
          fails++;
          $display("FAIL fault_lat1 step%0d fault=%b instr=%h", i, b0.fault, b0.instr);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      fe_req = $urandom_range(0, 3) != 0;
      fe_stall = $urandom_range(0, 3) == 0;
      ld_valid = $urandom_range(0, 1) == 1;
      ld_addr = AW'($urandom_range(0, DEPTH - 1));
      ld_data = $urandom();
      case ($urandom_range(0, 7))
        0: fe_off = $urandom();
        1: fe_off = 32'($urandom_range(0, DEPTH * 4 + 8));
        default: fe_off = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got(d) !== expect_r(d)) begin
          fails++;
          $display("FAIL random dut%0d iter%0d got=%h exp=%h", d, i, got(d), expect_r(d));
        end
      end
    end
    fe_stall = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    fe_req = 1'b1;
    fe_off = 32'h4;
    cycle();
    fe_off = 32'h8;
    cycle();
    fe_req = 1'b0;
    #2;
    assert_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got(d) !== BUB) begin
        fails++;
        $display("FAIL midop_reset dut%0d got=%h exp=%h", d, got(d), BUB);
      end
    end
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++;
    if ({b0.ld_ready, b0.running, b1.ld_ready, b1.running} !== 4'b1010) begin
      fails++;
      $display("FAIL reload_status got=%b exp=1010", {b0.ld_ready, b0.running, b1.ld_ready, b1.running});
    end
    fe_req = 1'b1;
    fe_off = 32'h0;
    cycle();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (got(d) !== expect_r(d) || got(d).v !== 1'b0) begin
        fails++;
        $display("FAIL fetch_in_load dut%0d got=%h exp=%h", d, got(d), expect_r(d));
      end
    end
    fe_req = 1'b0;
    ld_done = 1'b1;
    cycle();
    ld_done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      fe_req = i < 5;
      fe_off = (i == 4) ? 32'(DEPTH * 4 - 4) : 32'(i * 4);
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got(d) !== expect_r(d)) begin
          fails++;
          $display("FAIL after_reset dut%0d step%0d got=%h exp=%h", d, i, got(d), expect_r(d));
        end
      end
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    u_d0.u_ram.mem_q[2][32] = ~u_d0.u_ram.mem_q[2][32];
    u_d1.u_ram.mem_q[2][32] = ~u_d1.u_ram.mem_q[2][32];
    perr_m[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fe_req = i < 2;
      fe_off = (i == 0) ? 32'h8 : 32'h4;
      cycle();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (got(d) !== expect_r(d)) begin
          fails++;
          $display("FAIL parity dut%0d step%0d got=%h exp=%h", d, i, got(d), expect_r(d));
        end
      end
      if (i < 2) begin
        checks++;
        if (b0.par_err !== (i == 0) || b0.instr !== spec_w[i == 0 ? 2 : 1]) begin
          fails++;
          $display("FAIL parity_lat1 step%0d par_err=%b instr=%h", i, b0.par_err, b0.instr);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_seq_fetch();
    test_stall();
    test_faults();
    test_random();
    test_reset_midop();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
